// File: rtl/serial_pkg.sv
// Constants and state type shared by both ends of the bit-serial link.
package serial_pkg;
   localparam int WORD_W = 8;
   localparam int IDX_W  = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   typedef enum logic {FILL, PEND} deser_state_t;
endpackage

// File: rtl/word_hold.sv
// Single-entry valid/ready holding register: load sets valid, drain clears it,
// load and drain together replace the word, and the word is frozen while stalled.
import serial_pkg::*;

module word_hold (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_load_word,
   input  logic              i_word_ready,
   output logic              o_word_valid,
   output logic [WORD_W-1:0] o_data_word
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_word_valid <= 1'b0;
         o_data_word  <= '0;
      end else begin
         o_word_valid <= i_load || (o_word_valid && !i_word_ready);
         if (i_load) o_data_word <= i_load_word;
      end
   end

endmodule

// File: rtl/deser8.sv
// Bit-serial to parallel receiver: LSB-first shift stage with a FILL/PEND FSM
// feeding a holding stage, so the next word can stream in while one waits.
import serial_pkg::*;

module deser8 (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_bit_valid,
   input  logic              i_data_bit,
   output logic              o_bit_ready,
   output logic [IDX_W-1:0]  o_con_choice,
   output logic              o_busy,
   output logic [WORD_W-1:0] o_data_word,
   output logic              o_word_valid,
   input  logic              i_word_ready
);

   // Handshakes: a beat transfers on a rising edge where valid && ready;
   // ready never depends combinationally on the matching valid.

   deser_state_t      state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [WORD_W-1:0] shift, shift_nxt;
   logic              load;
   logic [WORD_W-1:0] load_word;
   logic              bit_acc, drain, hold_free;

   assign o_bit_ready  = (state == FILL);
   assign o_con_choice = idx;
   assign o_busy       = (state == PEND) || (idx != '0);

   assign bit_acc   = i_bit_valid && o_bit_ready;
   assign drain     = o_word_valid && i_word_ready;
   assign hold_free = !o_word_valid || i_word_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= FILL;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      shift_nxt = shift;
      load      = 1'b0;
      load_word = shift;
      // Clear wins over a same-cycle accept, so that bit is dropped.
      if (i_clear) begin
         state_nxt = FILL;
         idx_nxt   = '0;
         shift_nxt = '0;
      end else begin
         case (state)
            FILL: begin
               if (bit_acc) begin
                  shift_nxt[idx] = i_data_bit;
                  idx_nxt        = idx + 1'b1;
                  if (idx == LAST_IDX) begin
                     if (hold_free) begin
                        load      = 1'b1;
                        load_word = shift_nxt;
                     end else begin
                        state_nxt = PEND;
                     end
                  end
               end
            end
            PEND: begin
               if (drain) begin
                  load      = 1'b1;
                  load_word = shift;
                  state_nxt = FILL;
                  idx_nxt   = '0;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   word_hold u_hold (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (load),
      .i_load_word  (load_word),
      .i_word_ready (i_word_ready),
      .o_word_valid (o_word_valid),
      .o_data_word  (o_data_word)
   );

endmodule

// File: tb/tb_deser8.sv
// Self-checking bench for deser8: directed scenarios plus a randomized
// valid/ready stream checked against a word-level scoreboard.
module tb_deser8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       bit_valid = 1'b0;
   logic       data_bit = 1'b0;
   logic       bit_ready;
   logic [2:0] con_choice;
   logic       busy;
   logic [7:0] data_word;
   logic       word_valid;
   logic       word_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   deser8 dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clear      (clear),
      .i_bit_valid  (bit_valid),
      .i_data_bit   (data_bit),
      .o_bit_ready  (bit_ready),
      .o_con_choice (con_choice),
      .o_busy       (busy),
      .o_data_word  (data_word),
      .o_word_valid (word_valid),
      .i_word_ready (word_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, bit_ready, 1);
      check({tag, "_choice"}, con_choice, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, word_valid, 0);
      check({tag, "_data"}, data_word, 8'h00);
   endtask

   task automatic send_word(input logic [7:0] w, input string tag);
      for (int i = 0; i < 8; i++) begin
         bit_valid = 1'b1;
         data_bit  = w[i];
         check({tag, "_rdy"}, bit_ready, 1);
         check({tag, "_idx"}, con_choice, i);
         step();
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] cur;
      int         nbits;
      int         n_rx;
      int         n_sent;
      int         cyc;

      // reset
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      step();

      // basic word 8'hA5
      word_ready = 1'b1;
      send_word(8'hA5, "basic");
      check("basic_valid", word_valid, 1);
      check("basic_data", data_word, 8'hA5);
      check("basic_busy", busy, 0);
      step();
      check("basic_valid_1cyc", word_valid, 0);

      // back-to-back 3C then C3
      a = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            check("b2b_w0_valid", word_valid, 1);
            check("b2b_w0_data", data_word, 8'h3C);
            a = 8'hC3;
         end
         if (i == 9) check("b2b_gap", word_valid, 0);
         bit_valid = 1'b1;
         data_bit  = a[i % 8];
         check("b2b_ready", bit_ready, 1);
         step();
      end
      bit_valid = 1'b0;
      check("b2b_w1_valid", word_valid, 1);
      check("b2b_w1_data", data_word, 8'hC3);
      step();

      // backpressure
      word_ready = 1'b0;
      send_word(8'h0F, "bp0");
      check("bp_w0_valid", word_valid, 1);
      send_word(8'hF0, "bp1");
      bit_valid = 1'b1;
      data_bit  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("bp_pend_ready", bit_ready, 0);
         check("bp_pend_busy", busy, 1);
         check("bp_hold_data", data_word, 8'h0F);
         check("bp_hold_valid", word_valid, 1);
         step();
      end
      bit_valid  = 1'b0;
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      check("bp_rel_data", data_word, 8'hF0);
      check("bp_rel_valid", word_valid, 1);
      check("bp_rel_ready", bit_ready, 1);
      check("bp_rel_busy", busy, 0);
      word_ready = 1'b1;
      step();
      check("bp_drained", word_valid, 0);

      // clear with a simultaneous valid bit
      a = 8'h1F;
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1;
         data_bit  = a[i];
         step();
      end
      check("clr_pre_idx", con_choice, 5);
      clear     = 1'b1;
      data_bit  = 1'b1;
      step();
      clear     = 1'b0;
      bit_valid = 1'b0;
      check("clr_idx", con_choice, 0);
      check("clr_busy", busy, 0);
      send_word(8'h81, "clr_w");
      check("clr_valid", word_valid, 1);
      check("clr_data", data_word, 8'h81);
      step();

      // async reset mid-word
      a = 8'h07;
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         data_bit  = a[i];
         step();
      end
      bit_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("arst_mid");
      step();
      rst_n = 1'b1;
      step();

      // async reset with a stalled word
      word_ready = 1'b0;
      send_word(8'h5A, "arst_w");
      check("arst_stall_valid", word_valid, 1);
      check("arst_stall_data", data_word, 8'h5A);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("arst_hold");
      step();
      rst_n = 1'b1;
      step();

      // random stream vs scoreboard
      exp_q.delete();
      nbits  = 0;
      cur    = '0;
      n_rx   = 0;
      n_sent = 0;
      cyc    = 0;
      while (n_rx < 1000 && cyc < 60000) begin
         bit_valid  = (n_sent < 1000) && ($urandom_range(0, 3) != 0);
         data_bit   = 1'($urandom_range(0, 1));
         word_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (bit_valid && bit_ready) begin
            cur[nbits] = data_bit;
            nbits++;
            if (nbits == 8) begin
               exp_q.push_back(cur);
               n_sent++;
               nbits = 0;
            end
         end
         if (word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected_word", data_word, 32'hFFFF_FFFF);
            end else begin
               check("rnd_word", data_word, exp_q.pop_front());
            end
            n_rx++;
         end
         step();
         cyc++;
      end
      bit_valid  = 1'b0;
      word_ready = 1'b0;
      check("rnd_rx_count", n_rx, 1000);
      check("rnd_q_empty", exp_q.size(), 0);
      check("rnd_no_extra", word_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/deser8.md
# deser8

Bit-serial to parallel receiver: collects one data bit per accepted beat, LSB first, into an 8-bit word and presents completed words on a valid/ready output port. It is the receiving end of the bit-serial link whose transmit side walks a 3-bit select from 0 to 7 over an 8-bit word. A two-stage organisation (shift stage plus holding stage) lets the next word stream in while the previous word waits for its consumer.

## Interface
- WORD_W, 8, word width; fixed at 8 for this revision, `o_con_choice` is 3 bits.
- i_clk  input  1  clock; all state is updated on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_clear  input  1  synchronous abort of the word in progress, level-sensitive.
- i_bit_valid  input  1  `i_data_bit` is valid this cycle.
- i_data_bit  input  1  serial data bit.
- o_bit_ready  output  1  receiver accepts a bit this cycle.
- o_con_choice  output  3  bit index the next accepted bit is written to (0..7).
- o_busy  output  1  a partial or pending word is held in the shift stage.
- o_data_word  output  8  completed word.
- o_word_valid  output  1  `o_data_word` is valid.
- i_word_ready  input  1  consumer accepts `o_data_word` this cycle.

## Operation
- Bit accept: `i_bit_valid && o_bit_ready` at a rising edge. The bit is written to shift bit `o_con_choice`, then the index increments.
- Shift-stage FSM:
  - FILL, index 0..7: `o_bit_ready`=1.
    - Accept at index 7, with the holding stage free: load the holding stage, index becomes 0, stay in FILL.
    - "Holding free" means `!o_word_valid`, or `o_word_valid && i_word_ready` in the same cycle.
    - Accept at index 7, with the holding stage occupied and not draining: go to PEND.
  - PEND: `o_bit_ready`=0 and the complete word is kept.
    - On the holding stage draining (`o_word_valid && i_word_ready`): transfer the word, index becomes 0, go to FILL.
- Holding stage:
  - `o_word_valid` sets on load.
  - It clears on `o_word_valid && i_word_ready` when there is no load in the same cycle.
  - Load and drain in the same cycle: `o_word_valid` stays 1 and the new word replaces the old one.
  - `o_data_word` is stable while `o_word_valid && !i_word_ready`.
- `o_bit_ready` is a function of registered state only; it has no combinational path from any input.
- `o_busy` = (state==PEND) or (index != 0).
- i_clear:
  - Effect: index becomes 0, state becomes FILL, and the shift-stage contents (including a PEND word) are discarded.
  - The holding stage and `o_word_valid` are unaffected.
  - i_clear has priority over a simultaneous bit accept; that bit is dropped even though `o_bit_ready` was 1.
- Width rules: the index wraps 7→0 naturally in 3 bits. Bits in the shift stage not yet written for the current word carry no meaning and are never exposed.

## Timing
- Reset values: state FILL, index 0, `o_bit_ready`=1, `o_con_choice`=0, `o_busy`=0, `o_word_valid`=0, `o_data_word`=8'h00, shift stage 8'h00.
- Reset mid-word or mid-handshake: all of the above take effect immediately and asynchronously; partial and pending words are lost.
- Latency: 8th bit accepted at edge N with the holding stage free → `o_word_valid`=1 and the word visible on `o_data_word` after edge N.
- PEND release: drain at edge M → word visible after edge M, `o_bit_ready`=1 after edge M. This costs a one-cycle bubble on the input.
- Throughput: one word per 8 cycles with `i_bit_valid` and `i_word_ready` held high, with no bubbles.

## Structure
- Shared package `serial_pkg`:
  - WORD_W=8 and IDX_W=3.
  - `typedef enum logic {FILL, PEND} deser_state_t`.
  - The same constants are reused by the transmit side.
- One sub-module, `word_hold`: an 8-bit valid/ready holding register with load/drain, same-cycle replace, and stable-while-stalled behaviour.
- Index counter, shift stage and FSM live in `deser8`.

## Test plan
- Basic word: after reset, send bits 1,0,1,0,0,1,0,1 on consecutive cycles with `i_word_ready`=1.
  - `o_con_choice` steps 0..7.
  - `o_data_word`=8'hA5 and `o_word_valid`=1 for exactly one cycle after the 8th-bit edge.
- Back-to-back: stream 8'h3C then 8'hC3 continuously.
  - Both words are delivered, 8 cycles apart.
  - `o_bit_ready` never drops.
- Backpressure: `i_word_ready`=0, send 8'h0F then 8'hF0.
  - 8'h0F is held stable, state is PEND, `o_bit_ready`=0, `o_busy`=1.
  - Raise ready for one cycle: 8'hF0 appears the next cycle and `o_bit_ready` returns after one bubble.
- Clear: send 5 bits, assert `i_clear` together with a valid bit.
  - `o_con_choice`=0, `o_busy`=0, and the bit is dropped.
  - The next 8 bits (8'h81) produce exactly 8'h81.
- Async reset mid-word and while `o_word_valid`=1 with `i_word_ready`=0.
  - All outputs immediately reach their reset values, with no clock edge required.
- Random valid/ready gaps over 1000 words vs. a scoreboard.
  - No loss, duplication or reordering.
